hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
Parametrised EX-stage operand forwarding plus load-use hazard control for the in-order pipeline. Combines forwarding select and operand muxing with a sequential stall/bubble FSM. The FSM supports a configurable bubble count, global freeze, branch-flush abort and a saturating stall performance counter. Sits between the ID/EX register and the ALU, and drives PC/IF-ID hold and ID/EX bubble insertion.

Parameters:
DATA_W, 32, operand/result data width
ADDR_W, 5, register index width (2**ADDR_W registers; index 0 hard-wired zero)
LU_BUBBLES, 1, bubbles inserted per load-use hazard (1..15)
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rs1_IF_ID  in  ADDR_W  source 1 of instruction in ID
rs2_IF_ID  in  ADDR_W  source 2 of instruction in ID
use_rs1_IF_ID  in  1  ID instruction reads rs1
use_rs2_IF_ID  in  1  ID instruction reads rs2
rs1_ID_EX  in  ADDR_W  source 1 of instruction in EX
rs2_ID_EX  in  ADDR_W  source 2 of instruction in EX
rd_ID_EX  in  ADDR_W  destination of instruction in EX
MemRead_ID_EX  in  1  EX instruction is a load
rd_EX_MEM  in  ADDR_W  destination in MEM
RegWrite_EX_MEM  in  1  MEM instruction writes a register
MemRead_EX_MEM  in  1  MEM instruction is a load
rd_MEM_WB  in  ADDR_W  destination in WB
RegWrite_MEM_WB  in  1  WB instruction writes a register
rf_a, rf_b  in  DATA_W  register-file read data latched in ID/EX
alu_result_EX_MEM  in  DATA_W  EX/MEM result
wb_data_MEM_WB  in  DATA_W  final write-back data
freeze  in  1  global pipeline freeze (e.g. memory wait)
flush_in  in  1  branch/exception flush of IF/ID
perf_clr  in  1  synchronous clear of stall counter
forwardA, forwardB  out  2  select: 00 regfile, 10 EX/MEM, 01 MEM/WB
op_a, op_b  out  DATA_W  forwarded ALU operands
stall  out  1  hold PC and IF/ID
bubble_ID_EX  out  1  load NOP into ID/EX
stall_cycles  out  CNT_W  saturating count of stall cycles

Behaviour:
- Forwarding is combinational. Per operand, priority order:
  - EX/MEM when RegWrite_EX_MEM, rd_EX_MEM!=0, rd_EX_MEM==rs, and !MemRead_EX_MEM.
  - Otherwise MEM/WB when RegWrite_MEM_WB, rd_MEM_WB!=0, rd_MEM_WB==rs.
  - Otherwise regfile.
- op_a/op_b are muxed by forwardA/forwardB. Encoding 11 is never produced.
- Hazard detect (comb): haz = MemRead_ID_EX & rd_ID_EX!=0 & ((use_rs1_IF_ID & rd_ID_EX==rs1_IF_ID) | (use_rs2_IF_ID & rd_ID_EX==rs2_IF_ID)).
- FSM states IDLE, STALL; 4-bit down-counter cnt.
  - IDLE: if haz and !flush_in, then stall=1 and bubble_ID_EX=1 the same cycle. If LU_BUBBLES>1, go to STALL with cnt=LU_BUBBLES-1; otherwise remain IDLE.
  - STALL: stall=1 and bubble_ID_EX=1. cnt decrements each non-frozen cycle. When cnt==1 and the cycle is not frozen, go to IDLE.
- Priority is flush_in > freeze > detect/count:
  - flush_in=1: next state IDLE, cnt=0; stall and bubble_ID_EX are 0 that cycle.
  - freeze=1 (no flush): state and cnt hold; stall and bubble_ID_EX are driven per the current state; stall_cycles does not increment.
- stall_cycles increments on each clock where stall=1 and freeze=0, saturating at all-ones. perf_clr has priority over increment.
- Total stall per hazard = exactly LU_BUBBLES non-frozen cycles.
- Async reset (rst_n=0):
  - Immediately: state=IDLE, cnt=0, stall=0, bubble_ID_EX=0, stall_cycles=0.
  - Forwarding outputs remain combinational functions of their inputs.
  - Reset mid-STALL aborts the stall with no residue.

Test Plan:
1. rd_EX_MEM=5 and rd_MEM_WB=5, both RegWrite; rs1_ID_EX=5; alu=0xAAAA, wb=0xBBBB -> forwardA=10, op_a=0xAAAA. Same with MemRead_EX_MEM=1 -> forwardA=01, op_a=0xBBBB.
2. rd_EX_MEM=0 with RegWrite, rs1=rs2=0 -> forwardA=forwardB=00, op=rf values.
3. LU_BUBBLES=1: MemRead_ID_EX, rd_ID_EX=7, rs2_IF_ID=7, use_rs2=1 -> stall=bubble=1 for exactly 1 cycle, stall_cycles=1. Same with use_rs2=0 -> no stall.
4. LU_BUBBLES=3, hazard, freeze=1 for 2 cycles during STALL -> stall high for 5 cycles total, stall_cycles=3.
5. LU_BUBBLES=3, flush_in in 2nd stall cycle -> stall=0 that cycle, IDLE next. Separately, rst_n low mid-STALL -> stall=0 immediately, no stall after release.
6. CNT_W=4, 20 non-frozen stall cycles -> stall_cycles=15 (saturated). perf_clr -> 0 next edge.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_forward_ctrl
//
// EX-stage operand forwarding and load-use hazard control for an in-order
// pipeline. Sits between the ID/EX register and the ALU.
//
//   Forwarding (combinational):
//     forwardA/forwardB : operand source select (00 regfile, 10 EX/MEM, 01 MEM/WB)
//     op_a/op_b         : forwarded ALU operands
//
//   Load-use control (IDLE/STALL state machine):
//     stall             : hold PC and IF/ID
//     bubble_ID_EX      : load a NOP into ID/EX
//     stall_cycles      : saturating count of non-frozen stall cycles
//
//   Control inputs: freeze (global hold), flush_in (abort, highest priority),
//   perf_clr (synchronous counter clear), rst_n (asynchronous, active low).
// -----------------------------------------------------------------------------
module hazard_forward_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_IF_ID,
    input  logic [ADDR_W-1:0] rs2_IF_ID,
    input  logic              use_rs1_IF_ID,
    input  logic              use_rs2_IF_ID,
    input  logic [ADDR_W-1:0] rs1_ID_EX,
    input  logic [ADDR_W-1:0] rs2_ID_EX,
    input  logic [ADDR_W-1:0] rd_ID_EX,
    input  logic              MemRead_ID_EX,
    input  logic [ADDR_W-1:0] rd_EX_MEM,
    input  logic              RegWrite_EX_MEM,
    input  logic              MemRead_EX_MEM,
    input  logic [ADDR_W-1:0] rd_MEM_WB,
    input  logic              RegWrite_MEM_WB,
    input  logic [DATA_W-1:0] rf_a,
    input  logic [DATA_W-1:0] rf_b,
    input  logic [DATA_W-1:0] alu_result_EX_MEM,
    input  logic [DATA_W-1:0] wb_data_MEM_WB,
    input  logic              freeze,
    input  logic              flush_in,
    input  logic              perf_clr,
    output logic [1:0]        forwardA,
    output logic [1:0]        forwardB,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              stall,
    output logic              bubble_ID_EX,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EX = 2'b10;
    localparam logic [1:0] FWD_WB = 2'b01;

    // Value loaded into the bubble counter when entering STALL; the detecting
    // cycle itself already accounts for the first bubble.
    localparam logic [3:0] CNT_RELOAD = 4'(LU_BUBBLES - 1);

    typedef enum logic {
        IDLE,
        STALL
    } state_t;

    // -------------------------------------------------------------------------
    // Forwarding
    // -------------------------------------------------------------------------
    // A load in EX/MEM has no data yet, so it must not win; the load-use stall
    // guarantees the value arrives through MEM/WB instead.
    function automatic logic [1:0] fwd_sel(
        input logic [ADDR_W-1:0] rs,
        input logic [ADDR_W-1:0] rd_mem,
        input logic              wr_mem,
        input logic              ld_mem,
        input logic [ADDR_W-1:0] rd_wb,
        input logic              wr_wb
    );
        if (wr_mem && (rd_mem != '0) && (rd_mem == rs) && !ld_mem) begin
            return FWD_EX;
        end else if (wr_wb && (rd_wb != '0) && (rd_wb == rs)) begin
            return FWD_WB;
        end else begin
            return FWD_RF;
        end
    endfunction

    function automatic logic [DATA_W-1:0] fwd_mux(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] rf,
        input logic [DATA_W-1:0] ex,
        input logic [DATA_W-1:0] wb
    );
        case (sel)
            FWD_EX:  return ex;
            FWD_WB:  return wb;
            default: return rf;
        endcase
    endfunction

    always_comb begin
        forwardA = fwd_sel(rs1_ID_EX, rd_EX_MEM, RegWrite_EX_MEM, MemRead_EX_MEM,
                           rd_MEM_WB, RegWrite_MEM_WB);
        forwardB = fwd_sel(rs2_ID_EX, rd_EX_MEM, RegWrite_EX_MEM, MemRead_EX_MEM,
                           rd_MEM_WB, RegWrite_MEM_WB);
        op_a     = fwd_mux(forwardA, rf_a, alu_result_EX_MEM, wb_data_MEM_WB);
        op_b     = fwd_mux(forwardB, rf_b, alu_result_EX_MEM, wb_data_MEM_WB);
    end

    // -------------------------------------------------------------------------
    // Load-use detection
    // -------------------------------------------------------------------------
    logic haz;

    assign haz = MemRead_ID_EX && (rd_ID_EX != '0) &&
                 ((use_rs1_IF_ID && (rd_ID_EX == rs1_IF_ID)) ||
                  (use_rs2_IF_ID && (rd_ID_EX == rs2_IF_ID)));

    // -------------------------------------------------------------------------
    // Stall / bubble state machine
    // -------------------------------------------------------------------------
    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; combinational blocks below use blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        stall        = 1'b0;
        bubble_ID_EX = 1'b0;

        // NOTE: rst_n gates the control outputs directly so they drop the
        // moment reset asserts, even while a hazard is present on the inputs.
        if (!rst_n || flush_in) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (haz) begin
                        stall        = 1'b1;
                        bubble_ID_EX = 1'b1;
                        if (!freeze && (LU_BUBBLES > 1)) begin
                            state_nxt = STALL;
                            cnt_nxt   = CNT_RELOAD;
                        end
                    end
                end
                STALL: begin
                    stall        = 1'b1;
                    bubble_ID_EX = 1'b1;
                    if (!freeze) begin
                        if (cnt == 4'd1) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt - 4'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Stall performance counter (saturating; clear beats increment)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
        end else if (stall && !freeze && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
module tb_hazard_forward_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_IF_ID, rs2_IF_ID, rs1_ID_EX, rs2_ID_EX, rd_ID_EX;
    logic [4:0]  rd_EX_MEM, rd_MEM_WB;
    logic        use_rs1_IF_ID, use_rs2_IF_ID, MemRead_ID_EX;
    logic        RegWrite_EX_MEM, MemRead_EX_MEM, RegWrite_MEM_WB;
    logic [31:0] rf_a, rf_b, alu_result_EX_MEM, wb_data_MEM_WB;
    logic        freeze, flush_in, perf_clr;

    logic [1:0]  fa1, fb1, fa3, fb3;
    logic [31:0] opa1, opb1, opa3, opb3;
    logic        stall1, bub1, stall3, bub3;
    logic [15:0] sc1;
    logic [3:0]  sc3;

    int errors = 0;
    int checks = 0;

    // Reference model: remaining bubbles still owed after the current cycle and
    // the ideal stall count, per instance.
    int rem1 = 0, rem3 = 0;
    int cnt1 = 0, cnt3 = 0;

    hazard_forward_ctrl #(.DATA_W(32), .ADDR_W(5), .LU_BUBBLES(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
        .use_rs1_IF_ID(use_rs1_IF_ID), .use_rs2_IF_ID(use_rs2_IF_ID),
        .rs1_ID_EX(rs1_ID_EX), .rs2_ID_EX(rs2_ID_EX), .rd_ID_EX(rd_ID_EX),
        .MemRead_ID_EX(MemRead_ID_EX),
        .rd_EX_MEM(rd_EX_MEM), .RegWrite_EX_MEM(RegWrite_EX_MEM), .MemRead_EX_MEM(MemRead_EX_MEM),
        .rd_MEM_WB(rd_MEM_WB), .RegWrite_MEM_WB(RegWrite_MEM_WB),
        .rf_a(rf_a), .rf_b(rf_b), .alu_result_EX_MEM(alu_result_EX_MEM), .wb_data_MEM_WB(wb_data_MEM_WB),
        .freeze(freeze), .flush_in(flush_in), .perf_clr(perf_clr),
        .forwardA(fa1), .forwardB(fb1), .op_a(opa1), .op_b(opb1),
        .stall(stall1), .bubble_ID_EX(bub1), .stall_cycles(sc1)
    );

    hazard_forward_ctrl #(.DATA_W(32), .ADDR_W(5), .LU_BUBBLES(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
        .use_rs1_IF_ID(use_rs1_IF_ID), .use_rs2_IF_ID(use_rs2_IF_ID),
        .rs1_ID_EX(rs1_ID_EX), .rs2_ID_EX(rs2_ID_EX), .rd_ID_EX(rd_ID_EX),
        .MemRead_ID_EX(MemRead_ID_EX),
        .rd_EX_MEM(rd_EX_MEM), .RegWrite_EX_MEM(RegWrite_EX_MEM), .MemRead_EX_MEM(MemRead_EX_MEM),
        .rd_MEM_WB(rd_MEM_WB), .RegWrite_MEM_WB(RegWrite_MEM_WB),
        .rf_a(rf_a), .rf_b(rf_b), .alu_result_EX_MEM(alu_result_EX_MEM), .wb_data_MEM_WB(wb_data_MEM_WB),
        .freeze(freeze), .flush_in(flush_in), .perf_clr(perf_clr),
        .forwardA(fa3), .forwardB(fb3), .op_a(opa3), .op_b(opb3),
        .stall(stall3), .bubble_ID_EX(bub3), .stall_cycles(sc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit haz_ref();
        return MemRead_ID_EX && (rd_ID_EX != 0) &&
               ((use_rs1_IF_ID && rd_ID_EX == rs1_IF_ID) || (use_rs2_IF_ID && rd_ID_EX == rs2_IF_ID));
    endfunction

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (RegWrite_EX_MEM && rd_EX_MEM != 0 && rd_EX_MEM == rs && !MemRead_EX_MEM) return 2'b10;
        if (RegWrite_MEM_WB && rd_MEM_WB != 0 && rd_MEM_WB == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] op_ref(input logic [4:0] rs, input logic [31:0] rf);
        if (RegWrite_EX_MEM && rd_EX_MEM != 0 && rd_EX_MEM == rs && !MemRead_EX_MEM) return alu_result_EX_MEM;
        if (RegWrite_MEM_WB && rd_MEM_WB != 0 && rd_MEM_WB == rs) return wb_data_MEM_WB;
        return rf;
    endfunction

    function automatic bit stall_ref(input int rem);
        return rst_n && !flush_in && (rem > 0 || haz_ref());
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit s1, s3;
        s1 = stall_ref(rem1);
        s3 = stall_ref(rem3);
        if (perf_clr) cnt1 = 0; else if (s1 && !freeze && cnt1 < 65535) cnt1++;
        if (perf_clr) cnt3 = 0; else if (s3 && !freeze && cnt3 < 15) cnt3++;
        if (flush_in) begin
            rem1 = 0; rem3 = 0;
        end else if (!freeze) begin
            if (rem1 > 0) rem1--; else if (haz_ref()) rem1 = 1 - 1;
            if (rem3 > 0) rem3--; else if (haz_ref()) rem3 = 3 - 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_defaults();
        {rs1_IF_ID, rs2_IF_ID, rs1_ID_EX, rs2_ID_EX, rd_ID_EX, rd_EX_MEM, rd_MEM_WB} = '0;
        {use_rs1_IF_ID, use_rs2_IF_ID, MemRead_ID_EX} = '0;
        {RegWrite_EX_MEM, MemRead_EX_MEM, RegWrite_MEM_WB} = '0;
        {rf_a, rf_b, alu_result_EX_MEM, wb_data_MEM_WB} = '0;
        {freeze, flush_in, perf_clr} = '0;
    endtask

    task automatic drive_hazard();
        MemRead_ID_EX = 1'b1; rd_ID_EX = 5'd7;
        rs2_IF_ID = 5'd7; use_rs2_IF_ID = 1'b1;
        rs1_IF_ID = 5'd3; use_rs1_IF_ID = 1'b1;
    endtask

    task automatic clear_counters();
        drive_defaults();
        repeat (4) tick();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_defaults();
        rst_n = 1'b0;
        rs1_ID_EX = 5'd5; rd_EX_MEM = 5'd5; RegWrite_EX_MEM = 1'b1;
        rf_a = 32'h1; alu_result_EX_MEM = 32'h1234;
        drive_hazard();
        #2;
        checks++;
        if ({stall1, bub1, stall3, bub3} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {stall1, bub1, stall3, bub3});
        end
        checks++;
        if (sc1 !== 16'd0 || sc3 !== 4'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", sc1, sc3);
        end
        checks++;
        if (fa1 !== 2'b10 || opa1 !== 32'h1234) begin
            errors++; $display("FAIL reset_fwd: got %b/%h expected 10/00001234", fa1, opa1);
        end
        drive_defaults();
        #1 rst_n = 1'b1;
        rem1 = 0; rem3 = 0; cnt1 = 0; cnt3 = 0;
        @(negedge clk);
        checks++;
        if ({stall1, stall3} !== 2'b00) begin
            errors++; $display("FAIL post_reset_stall: got %b expected 00", {stall1, stall3});
        end
        tick();
    endtask

    task automatic test_forward_priority();
        drive_defaults();
        rd_EX_MEM = 5'd5; RegWrite_EX_MEM = 1'b1;
        rd_MEM_WB = 5'd5; RegWrite_MEM_WB = 1'b1;
        rs1_ID_EX = 5'd5; rs2_ID_EX = 5'd6;
        alu_result_EX_MEM = 32'hAAAA; wb_data_MEM_WB = 32'hBBBB;
        rf_a = 32'h1111; rf_b = 32'h2222;
        @(negedge clk);
        checks++;
        if ({fa1, fb1, fa3} !== 6'b10_00_10 || opa1 !== 32'hAAAA || opb1 !== 32'h2222) begin
            errors++; $display("FAIL fwd_ex_priority: got %b %b %h %h expected 10 00 0000aaaa 00002222", fa1, fb1, opa1, opb1);
        end
        MemRead_EX_MEM = 1'b1;
        #1;
        checks++;
        if (fa1 !== 2'b01 || opa1 !== 32'hBBBB) begin
            errors++; $display("FAIL fwd_load_skip: got %b %h expected 01 0000bbbb", fa1, opa1);
        end
        RegWrite_MEM_WB = 1'b0;
        #1;
        checks++;
        if (fa1 !== 2'b00 || opa1 !== 32'h1111) begin
            errors++; $display("FAIL fwd_regfile: got %b %h expected 00 00001111", fa1, opa1);
        end
        tick();
    endtask

    task automatic test_forward_zero();
        drive_defaults();
        rd_EX_MEM = 5'd0; RegWrite_EX_MEM = 1'b1;
        rd_MEM_WB = 5'd0; RegWrite_MEM_WB = 1'b1;
        rs1_ID_EX = 5'd0; rs2_ID_EX = 5'd0;
        alu_result_EX_MEM = 32'hDEAD; wb_data_MEM_WB = 32'hBEEF;
        rf_a = 32'h3333; rf_b = 32'h4444;
        @(negedge clk);
        checks++;
        if ({fa1, fb1} !== 4'b0000 || opa1 !== 32'h3333 || opb1 !== 32'h4444) begin
            errors++; $display("FAIL fwd_x0: got %b %b %h %h expected 00 00 00003333 00004444", fa1, fb1, opa1, opb1);
        end
        tick();
    endtask

    task automatic test_load_use();
        clear_counters();
        drive_hazard();
        @(negedge clk);
        checks++;
        if ({stall1, bub1} !== 2'b11) begin
            errors++; $display("FAIL lu1_active: got %b expected 11", {stall1, bub1});
        end
        tick();
        drive_defaults();
        @(negedge clk);
        checks++;
        if ({stall1, bub1} !== 2'b00 || sc1 !== 16'd1) begin
            errors++; $display("FAIL lu1_release: got %b cnt=%0d expected 00 cnt=1", {stall1, bub1}, sc1);
        end
        repeat (3) tick();
        drive_hazard();
        use_rs2_IF_ID = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall1, bub1, stall3, bub3} !== 4'b0000) begin
            errors++; $display("FAIL lu_unused_src: got %b expected 0000", {stall1, bub1, stall3, bub3});
        end
        tick();
        drive_defaults();
    endtask

    task automatic test_bubble_freeze();
        int n;
        n = 0;
        clear_counters();
        drive_hazard();
        for (int i = 0; i < 8; i++) begin
            if (i >= 1) MemRead_ID_EX = 1'b0;
            freeze = (i == 1 || i == 2);
            @(negedge clk);
            checks++;
            if ({stall3, bub3} !== {2{i < 5}}) begin
                errors++; $display("FAIL lu3_freeze_cyc%0d: got %b expected %b", i, {stall3, bub3}, {2{i < 5}});
            end
            n += int'(stall3);
            tick();
        end
        freeze = 1'b0;
        @(negedge clk);
        checks++;
        if (n != 5 || sc3 !== 4'd3) begin
            errors++; $display("FAIL lu3_freeze_total: got len=%0d cnt=%0d expected len=5 cnt=3", n, sc3);
        end
        drive_defaults();
    endtask

    task automatic test_flush_and_reset();
        clear_counters();
        drive_hazard();
        @(negedge clk);
        tick();
        drive_defaults();
        @(negedge clk);
        flush_in = 1'b1;
        #1;
        checks++;
        if ({stall3, bub3} !== 2'b00) begin
            errors++; $display("FAIL flush_same_cycle: got %b expected 00", {stall3, bub3});
        end
        tick();
        flush_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (stall3 !== 1'b0) begin
                errors++; $display("FAIL flush_after%0d: got %b expected 0", i, stall3);
            end
            tick();
        end
        drive_hazard();
        @(negedge clk);
        tick();
        drive_defaults();
        @(negedge clk);
        checks++;
        if (stall3 !== 1'b1) begin
            errors++; $display("FAIL rst_pre_stall: got %b expected 1", stall3);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({stall3, bub3} !== 2'b00 || sc3 !== 4'd0) begin
            errors++; $display("FAIL rst_mid_stall: got %b cnt=%0d expected 00 cnt=0", {stall3, bub3}, sc3);
        end
        #1 rst_n = 1'b1;
        rem1 = 0; rem3 = 0; cnt1 = 0; cnt3 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if (stall3 !== 1'b0) begin
                errors++; $display("FAIL rst_residue%0d: got %b expected 0", i, stall3);
            end
        end
        tick();
    endtask

    task automatic test_saturation();
        clear_counters();
        drive_hazard();
        repeat (20) tick();
        @(negedge clk);
        checks++;
        if (sc3 !== 4'd15 || sc1 !== 16'd20) begin
            errors++; $display("FAIL cnt_saturate: got %0d/%0d expected 15/20", sc3, sc1);
        end
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        checks++;
        if (sc3 !== 4'd0 || sc1 !== 16'd0) begin
            errors++; $display("FAIL cnt_clear: got %0d/%0d expected 0/0", sc3, sc1);
        end
        drive_defaults();
        repeat (4) tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 500; i++) begin
            rs1_IF_ID = 5'($urandom_range(0, 3)); rs2_IF_ID = 5'($urandom_range(0, 3));
            rs1_ID_EX = 5'($urandom_range(0, 3)); rs2_ID_EX = 5'($urandom_range(0, 3));
            rd_ID_EX  = 5'($urandom_range(0, 3)); rd_EX_MEM = 5'($urandom_range(0, 3));
            rd_MEM_WB = 5'($urandom_range(0, 3));
            use_rs1_IF_ID = 1'($urandom); use_rs2_IF_ID = 1'($urandom);
            MemRead_ID_EX = 1'($urandom); MemRead_EX_MEM = ($urandom_range(0, 3) == 0);
            RegWrite_EX_MEM = 1'($urandom); RegWrite_MEM_WB = 1'($urandom);
            rf_a = $urandom; rf_b = $urandom; alu_result_EX_MEM = $urandom; wb_data_MEM_WB = $urandom;
            freeze   = ($urandom_range(0, 3) == 0);
            flush_in = ($urandom_range(0, 7) == 0);
            perf_clr = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            checks++;
            if ({fa1, fb1, fa3, fb3} !== {fwd_ref(rs1_ID_EX), fwd_ref(rs2_ID_EX), fwd_ref(rs1_ID_EX), fwd_ref(rs2_ID_EX)}) begin
                errors++; $display("FAIL rnd_fwd%0d: got %b%b expected %b%b", i, fa1, fb1, fwd_ref(rs1_ID_EX), fwd_ref(rs2_ID_EX));
            end
            checks++;
            if (opa1 !== op_ref(rs1_ID_EX, rf_a) || opb1 !== op_ref(rs2_ID_EX, rf_b) || opa3 !== opa1 || opb3 !== opb1) begin
                errors++; $display("FAIL rnd_ops%0d: got %h %h expected %h %h", i, opa1, opb1, op_ref(rs1_ID_EX, rf_a), op_ref(rs2_ID_EX, rf_b));
            end
            checks++;
            if ({stall1, bub1, stall3, bub3} !== {{2{stall_ref(rem1)}}, {2{stall_ref(rem3)}}}) begin
                errors++; $display("FAIL rnd_ctrl%0d: got %b expected %b", i, {stall1, bub1, stall3, bub3}, {{2{stall_ref(rem1)}}, {2{stall_ref(rem3)}}});
            end
            checks++;
            if (sc1 !== 16'(cnt1) || sc3 !== 4'(cnt3)) begin
                errors++; $display("FAIL rnd_cnt%0d: got %0d/%0d expected %0d/%0d", i, sc1, sc3, cnt1, cnt3);
            end
            tick();
        end
        drive_defaults();
    endtask

    initial begin
        test_reset();
        test_forward_priority();
        test_forward_zero();
        test_load_use();
        test_bubble_freeze();
        test_flush_and_reset();
        test_saturation();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
